alu_cmd_driver: RTL

Command-side initiator for the team's 4-bit combinational ALU. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It drives registered operand and opcode lines into the ALU, samples the ALU result, and returns it with status flags over a second valid/ready handshake. It also keeps an accumulator so commands can chain on the previous result.

---
 rtl/alu_cmd_driver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the 4-bit combinational ALU: queues commands, drives registered ALU inputs, returns result + flags.
// Latency: command accepted at edge E0 into an idle empty block -> rsp_valid after E2; one response per 2 cycles sustained.
// Backpressure: cmd_ready = !full (no bypass); rsp_* held stable while rsp_valid && !rsp_ready; queue fills while response stalls.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   cmd_valid/cmd_ready, cmd_op, cmd_a, command handshake and fields; cmd_use_acc
//   cmd_b, cmd_use_acc                  replaces operand A with the accumulator
//   alu_a, alu_b, alu_sel               registered ALU operands/opcode
//   alu_result                          combinational ALU output
//   rsp_valid/rsp_ready, rsp_data,      response handshake, result (0 on error),
//   rsp_op, rsp_err, rsp_zero           opcode, error flag, zero flag
//   busy                                queue non-empty or FSM not idle

module cmd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
endmodule

module alu_cmd_driver #(
   parameter int WIDTH = 4,
   parameter int OPW   = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OPW-1:0]   cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_use_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [OPW-1:0]   rsp_op,
   output logic             rsp_err,
   output logic             rsp_zero,
   output logic             busy
);
   localparam int EW = OPW + 2*WIDTH + 1;

   typedef enum logic [1:0] {IDLE, SAMPLE, RESP} state_t;

   state_t           state, nxt_state;
   logic             rdy_en;
   logic             fifo_full, fifo_empty, pop;
   logic [EW-1:0]    fifo_din, fifo_dout;
   logic [OPW-1:0]   f_op;
   logic [WIDTH-1:0] f_a, f_b;
   logic             f_use_acc;
   logic [WIDTH-1:0] acc, nxt_acc;
   logic [WIDTH-1:0] nxt_alu_a, nxt_alu_b, nxt_rsp_data;
   logic [OPW-1:0]   nxt_alu_sel, nxt_rsp_op;
   logic             nxt_rsp_valid, nxt_rsp_err, nxt_rsp_zero;
   logic             err;

   // rdy_en holds cmd_ready low through reset and releases it one edge later.
   assign cmd_ready = rdy_en && !fifo_full;
   assign fifo_din  = {cmd_op, cmd_a, cmd_b, cmd_use_acc};
   assign {f_op, f_a, f_b, f_use_acc} = fifo_dout;
   assign busy      = !fifo_empty || (state != IDLE);

   cmd_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid && cmd_ready),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rdy_en    <= 1'b0;
         acc       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_op    <= '0;
         rsp_err   <= 1'b0;
         rsp_zero  <= 1'b0;
      end else begin
         state     <= nxt_state;
         rdy_en    <= 1'b1;
         acc       <= nxt_acc;
         alu_a     <= nxt_alu_a;
         alu_b     <= nxt_alu_b;
         alu_sel   <= nxt_alu_sel;
         rsp_valid <= nxt_rsp_valid;
         rsp_data  <= nxt_rsp_data;
         rsp_op    <= nxt_rsp_op;
         rsp_err   <= nxt_rsp_err;
         rsp_zero  <= nxt_rsp_zero;
      end
   end

   always_comb begin
      nxt_state     = state;
      nxt_acc       = acc;
      nxt_alu_a     = alu_a;
      nxt_alu_b     = alu_b;
      nxt_alu_sel   = alu_sel;
      nxt_rsp_valid = rsp_valid;
      nxt_rsp_data  = rsp_data;
      nxt_rsp_op    = rsp_op;
      nxt_rsp_err   = rsp_err;
      nxt_rsp_zero  = rsp_zero;
      pop           = 1'b0;
      // Divide by zero or the undefined all-ones opcode.
      err = ((alu_sel == OPW'(4)) && (alu_b == '0)) || (alu_sel == '1);

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               nxt_alu_a   = f_use_acc ? acc : f_a;
               nxt_alu_b   = f_b;
               nxt_alu_sel = f_op;
               nxt_state   = SAMPLE;
            end else begin
               nxt_alu_a   = '0;
               nxt_alu_b   = '0;
               nxt_alu_sel = '0;
            end
         end
         SAMPLE: begin
            nxt_rsp_data  = err ? '0 : alu_result;
            nxt_rsp_op    = alu_sel;
            nxt_rsp_err   = err;
            nxt_rsp_zero  = err || (alu_result == '0);
            nxt_rsp_valid = 1'b1;
            if (!err)
               nxt_acc = alu_result;
            nxt_state = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               // Valid drops after every handshake so a chained command's
               // SAMPLE cycle never re-presents the old response.
               nxt_rsp_valid = 1'b0;
               if (!fifo_empty) begin
                  // acc already holds the result just returned.
                  pop         = 1'b1;
                  nxt_alu_a   = f_use_acc ? acc : f_a;
                  nxt_alu_b   = f_b;
                  nxt_alu_sel = f_op;
                  nxt_state   = SAMPLE;
               end else begin
                  nxt_alu_a   = '0;
                  nxt_alu_b   = '0;
                  nxt_alu_sel = '0;
                  nxt_state   = IDLE;
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end
endmodule
